// File: rtl/l2_sram_pkg.sv
// Shared definitions for the L2 SRAM array family: access-ratio limit,
// segment-width helper and the request-kind encoding.
package l2_sram_pkg;

    // Longest supported access ratio in clocks per request.
    localparam int MCP_MAX = 4;

    // Busy counter width: it must hold MCP_MAX-1.
    localparam int CNT_W = $clog2(MCP_MAX);

    // Request kind as carried on req_write.
    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_kind_e;

    // Width of one write-mask segment.
    function automatic int seg_width(input int data_w, input int segs);
        return data_w / segs;
    endfunction

endpackage

// File: rtl/sram_mcp_timer.sv
// Access timer for the MCP array. It has two parts:
//  - a busy down-counter that gates req_ready;
//  - an MCP-deep shift of the "read pending" bit that produces resp_valid.
// resp_load_o is the value the last pipe stage will take at the coming edge.
// The top uses it to capture read data into its output register.
module sram_mcp_timer
    import l2_sram_pkg::*;
#(
    parameter int MCP = 2
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic req_valid_i,
    input  logic req_read_i,
    output logic req_ready_o,
    output logic fire_o,
    output logic resp_load_o,
    output logic resp_valid_o
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MCP - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic             ready_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [MCP-1:0]   pipe_q;
    logic [MCP-1:0]   pipe_d;
    logic             fire_s;

    // A request is never taken while reset is asserted, even if ready is still high.
    assign fire_s       = req_valid_i & ready_q & ~reset_i;
    assign fire_o       = fire_s;
    assign req_ready_o  = ready_q;
    assign resp_valid_o = pipe_q[MCP-1];
    assign resp_load_o  = pipe_d[MCP-1];

    // Busy counter: load MCP-1 on accept, then count down to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (fire_s) begin
            cnt_d = CNT_LOAD;
        end else if (cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Read-pending shift: an accepted read surfaces at the last stage MCP cycles later.
    always_comb begin
        pipe_d    = {MCP{1'b0}};
        pipe_d[0] = fire_s & req_read_i;
        for (int i = 1; i < MCP; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // State register: ready is registered, so it stays low for the first cycle after reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            ready_q <= 1'b0;
            cnt_q   <= CNT_ZERO;
            pipe_q  <= {MCP{1'b0}};
        end else begin
            ready_q <= (cnt_d == CNT_ZERO);
            cnt_q   <= cnt_d;
            pipe_q  <= pipe_d;
        end
    end

endmodule

// File: rtl/sram_mcp_array.sv
// Single-port SRAM model for the L2 data/tag arrays at a multicycle access ratio.
// The array accepts one request every MCP clocks and supports per-segment write masks.
// A read answers with a one-cycle resp_valid pulse exactly MCP cycles after it is accepted.
module sram_mcp_array
    import l2_sram_pkg::*;
#(
    parameter  int SETS   = 512,
    parameter  int DATA_W = 512,
    parameter  int SEGS   = 1,
    parameter  int MCP    = 2,
    parameter  int HOLD   = 1,
    localparam int ADDR_W = $clog2(SETS),
    localparam int SEG_W  = seg_width(DATA_W, SEGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [SEGS-1:0]   req_wmask,
    output logic              resp_valid,
    output logic [DATA_W-1:0] rdata
);

    // Elaboration-time legality checks.
    if ((MCP < 1) || (MCP > MCP_MAX)) begin : g_bad_mcp
        $error("sram_mcp_array: MCP must be in 1..%0d", MCP_MAX);
    end
    if ((SEGS < 1) || ((DATA_W % SEGS) != 0)) begin : g_bad_segs
        $error("sram_mcp_array: DATA_W must be a multiple of SEGS");
    end
    if (SETS < 2) begin : g_bad_sets
        $error("sram_mcp_array: SETS must be at least 2");
    end

    // Depth widened by one bit so the range check also works for non-power-of-2 depths.
    localparam logic [ADDR_W:0] SETS_W = (ADDR_W + 1)'(SETS);

    logic [DATA_W-1:0] mem_q [SETS];
    logic [ADDR_W-1:0] rd_addr_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    logic              fire_s;
    logic              resp_load_s;
    logic              is_write_s;
    logic              wr_addr_ok_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic              rd_addr_ok_s;
    logic [DATA_W-1:0] rd_data_s;

    assign is_write_s   = (req_kind_e'(req_write) == REQ_WRITE);
    assign wr_addr_ok_s = ({1'b0, req_addr} < SETS_W);

    // MCP=1 captures data at the accept edge itself, so it reads the live address.
    // Longer ratios use the latched address; the array cannot change while the access is busy.
    assign rd_addr_s    = (MCP == 1) ? req_addr : rd_addr_q;
    assign rd_addr_ok_s = ({1'b0, rd_addr_s} < SETS_W);
    assign rd_data_s    = rd_addr_ok_s ? mem_q[rd_addr_s] : {DATA_W{1'b0}};

    sram_mcp_timer #(
        .MCP (MCP)
    ) u_timer (
        .clock_i      (clock),
        .reset_i      (reset),
        .req_valid_i  (req_valid),
        .req_read_i   (~is_write_s),
        .req_ready_o  (req_ready),
        .fire_o       (fire_s),
        .resp_load_o  (resp_load_s),
        .resp_valid_o (resp_valid)
    );

    // Masked segment write on an accepted in-range write.
    // Unmasked segments keep their value, and the array contents are never reset.
    always_ff @(posedge clock) begin
        if (fire_s && is_write_s && wr_addr_ok_s) begin
            for (int i = 0; i < SEGS; i++) begin
                if (req_wmask[i]) begin
                    mem_q[req_addr][i*SEG_W +: SEG_W] <= req_wdata[i*SEG_W +: SEG_W];
                end
            end
        end
    end

    // Next value of the output register: load on a response, otherwise hold or clear per HOLD.
    always_comb begin
        rdata_d = rdata_q;
        if (resp_load_s) begin
            rdata_d = rd_data_s;
        end else if (HOLD != 0) begin
            rdata_d = rdata_q;
        end else begin
            rdata_d = {DATA_W{1'b0}};
        end
    end

    // Read address latch and the registered read-data output.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_addr_q <= {ADDR_W{1'b0}};
            rdata_q   <= {DATA_W{1'b0}};
        end else begin
            if (fire_s && !is_write_s) begin
                rd_addr_q <= req_addr;
            end
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: tb/tb_sram_mcp_array.sv
// Self-checking bench for sram_mcp_array: four instances at MCP 1..4.
// The bench runs directed sequences first, then random traffic against a scoreboard.
module tb_sram_mcp_array;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]        rst;
    logic [3:0]        vld;
    logic [3:0]        wr;
    logic [3:0]        rdy;
    logic [3:0]        rv;
    logic [3:0][8:0]   addr;
    logic [3:0][511:0] wd;
    logic [3:0][511:0] rd;
    logic [3:0][3:0]   wm;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    int mcp_of  [4] = '{1, 2, 3, 4};
    int hold_of [4] = '{1, 1, 0, 1};
    int sets_of [4] = '{16, 512, 16, 12};

    sram_mcp_array #(.SETS(16), .DATA_W(512), .SEGS(4), .MCP(1), .HOLD(1)) u0 (
        .clock(clk), .reset(rst[0]), .req_valid(vld[0]), .req_ready(rdy[0]),
        .req_write(wr[0]), .req_addr(addr[0][3:0]), .req_wdata(wd[0]), .req_wmask(wm[0]),
        .resp_valid(rv[0]), .rdata(rd[0]));
    sram_mcp_array #(.SETS(512), .DATA_W(512), .SEGS(4), .MCP(2), .HOLD(1)) u1 (
        .clock(clk), .reset(rst[1]), .req_valid(vld[1]), .req_ready(rdy[1]),
        .req_write(wr[1]), .req_addr(addr[1]), .req_wdata(wd[1]), .req_wmask(wm[1]),
        .resp_valid(rv[1]), .rdata(rd[1]));
    sram_mcp_array #(.SETS(16), .DATA_W(512), .SEGS(4), .MCP(3), .HOLD(0)) u2 (
        .clock(clk), .reset(rst[2]), .req_valid(vld[2]), .req_ready(rdy[2]),
        .req_write(wr[2]), .req_addr(addr[2][3:0]), .req_wdata(wd[2]), .req_wmask(wm[2]),
        .resp_valid(rv[2]), .rdata(rd[2]));
    sram_mcp_array #(.SETS(12), .DATA_W(512), .SEGS(4), .MCP(4), .HOLD(1)) u3 (
        .clock(clk), .reset(rst[3]), .req_valid(vld[3]), .req_ready(rdy[3]),
        .req_write(wr[3]), .req_addr(addr[3][3:0]), .req_wdata(wd[3]), .req_wmask(wm[3]),
        .resp_valid(rv[3]), .rdata(rd[3]));

    // Scoreboard state for the random phase.
    logic [511:0] sb_mem [16];
    int           sb_due_c [$];
    logic [511:0] sb_due_d [$];
    logic [511:0] sb_last;
    int           sb_ready_at;

    localparam logic [511:0] ZERO = 512'd0;
    localparam logic [511:0] ONES = {512{1'b1}};

    task automatic check_eq(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [511:0] pat32(input logic [31:0] w);
        return {16{w}};
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic drive(input int k, input logic v, input logic w, input int a,
                         input logic [511:0] d, input logic [3:0] m);
        vld[k]  = v;
        wr[k]   = w;
        addr[k] = 9'(a);
        wd[k]   = d;
        wm[k]   = m;
    endtask

    // Present one request for exactly one cycle once ready is high; returns in the cycle after accept.
    task automatic issue(input int k, input logic w, input int a, input logic [511:0] d,
                         input logic [3:0] m, input string tag);
        int n = 0;
        while (!rdy[k] && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, " ready"}, 512'(rdy[k]), 512'(1'b1));
        drive(k, 1'b1, w, a, d, m);
        tick();
        drive(k, 1'b0, 1'b0, 0, ZERO, 4'h0);
    endtask

    // Wait for a response; it must arrive lat cycles after issue() returned and carry exp.
    task automatic wait_resp(input int k, input string tag, input logic [511:0] exp, input int lat);
        int n = 0;
        while (!rv[k] && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, " resp"}, 512'(rv[k]), 512'(1'b1));
        check_eq({tag, " latency"}, 512'(n), 512'(lat));
        check_eq({tag, " data"}, rd[k], exp);
    endtask

    // One scoreboard cycle: check outputs against the model, then account for this cycle's request.
    task automatic sb_step(input int k, output bit fired);
        bit exp_rv;
        bit exp_rdy;
        int a;
        exp_rv = (sb_due_c.size() > 0) && (sb_due_c[0] == cyc);
        check_eq("sb resp_valid", 512'(rv[k]), 512'(exp_rv));
        if (exp_rv) begin
            check_eq("sb rdata", rd[k], sb_due_d[0]);
            sb_last = sb_due_d[0];
            void'(sb_due_c.pop_front());
            void'(sb_due_d.pop_front());
        end else begin
            check_eq("sb rdata idle", rd[k], (hold_of[k] != 0) ? sb_last : ZERO);
            if ((sb_due_c.size() > 0) && (sb_due_c[0] < cyc)) begin
                void'(sb_due_c.pop_front());
                void'(sb_due_d.pop_front());
            end
        end
        exp_rdy = (cyc >= sb_ready_at);
        check_eq("sb req_ready", 512'(rdy[k]), 512'(exp_rdy));
        fired = vld[k] && exp_rdy;
        if (fired) begin
            a = int'(addr[k]);
            sb_ready_at = cyc + mcp_of[k];
            if (wr[k]) begin
                if (a < sets_of[k]) begin
                    for (int s = 0; s < 4; s++) begin
                        if (wm[k][s]) sb_mem[a][s*128 +: 128] = wd[k][s*128 +: 128];
                    end
                end
            end else begin
                sb_due_c.push_back(cyc + mcp_of[k]);
                sb_due_d.push_back((a < sets_of[k]) ? sb_mem[a] : ZERO);
            end
        end
        tick();
    endtask

    task automatic sb_run(input int k);
        bit fired;
        int i;
        int guard;
        drive(k, 1'b0, 1'b0, 0, ZERO, 4'h0);
        rst[k] = 1'b1;
        tick();
        tick();
        rst[k] = 1'b0;
        sb_ready_at = cyc + 1;
        sb_last = ZERO;
        sb_due_c.delete();
        sb_due_d.delete();
        i = 0;
        guard = 0;
        while (i < 16 && guard < 200) begin
            drive(k, 1'b1, 1'b1, i, rnd512(), 4'hF);
            sb_step(k, fired);
            if (fired) i++;
            guard++;
        end
        for (int c = 0; c < 300; c++) begin
            drive(k, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 15)), rnd512(), 4'($urandom_range(0, 15)));
            sb_step(k, fired);
        end
        drive(k, 1'b0, 1'b0, 0, ZERO, 4'h0);
        for (int c = 0; c < 6; c++) sb_step(k, fired);
        check_eq("sb drained", 512'(sb_due_c.size()), 512'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 4'hF;
        for (int k = 0; k < 4; k++) drive(k, 1'b0, 1'b0, 0, ZERO, 4'h0);

        // Test 1: reset for three cycles, then release.
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq("rst ready", 512'(rdy), 512'(4'h0));
            check_eq("rst resp_valid", 512'(rv), 512'(4'h0));
            for (int k = 0; k < 4; k++) check_eq("rst rdata", rd[k], ZERO);
        end
        rst = 4'h0;
        check_eq("release ready first", 512'(rdy), 512'(4'h0));
        tick();
        check_eq("release ready next", 512'(rdy), 512'(4'hF));
        check_eq("release resp_valid", 512'(rv), 512'(4'h0));
        for (int k = 0; k < 4; k++) check_eq("release rdata", rd[k], ZERO);

        // Test 2: MCP=2 write then read of addr 5, then hold.
        drive(1, 1'b1, 1'b1, 5, pat32(32'hA5A5_A5A5), 4'hF);
        tick();
        check_eq("t2 busy T+1", 512'(rdy[1]), 512'(1'b0));
        drive(1, 1'b0, 1'b0, 0, ZERO, 4'h0);
        tick();
        check_eq("t2 ready T+2", 512'(rdy[1]), 512'(1'b1));
        drive(1, 1'b1, 1'b0, 5, ZERO, 4'h0);
        tick();
        check_eq("t2 no resp T+3", 512'(rv[1]), 512'(1'b0));
        check_eq("t2 busy T+3", 512'(rdy[1]), 512'(1'b0));
        drive(1, 1'b0, 1'b0, 0, ZERO, 4'h0);
        tick();
        check_eq("t2 resp T+4", 512'(rv[1]), 512'(1'b1));
        check_eq("t2 rdata T+4", rd[1], pat32(32'hA5A5_A5A5));
        check_eq("t2 ready T+4", 512'(rdy[1]), 512'(1'b1));
        for (int c = 5; c <= 10; c++) begin
            tick();
            check_eq("t2 pulse end", 512'(rv[1]), 512'(1'b0));
            check_eq("t2 hold", rd[1], pat32(32'hA5A5_A5A5));
        end

        // Test 3: segment masks, with the read following the writes back to back.
        issue(1, 1'b1, 9, ONES, 4'hF, "t3 wr ones");
        issue(1, 1'b1, 9, ZERO, 4'b0101, "t3 wr mask");
        issue(1, 1'b0, 9, ZERO, 4'h0, "t3 rd");
        wait_resp(1, "t3", {{128{1'b1}}, {128{1'b0}}, {128{1'b1}}, {128{1'b0}}}, 1);

        // Test 4: MCP=1 back-to-back reads.
        for (int i = 0; i < 3; i++) issue(0, 1'b1, i, pat32(32'hC0DE_0000 | 32'(i)), 4'hF, "t4 wr");
        drive(0, 1'b1, 1'b0, 0, ZERO, 4'h0);
        check_eq("t4 ready c0", 512'(rdy[0]), 512'(1'b1));
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t4 resp", 512'(rv[0]), 512'(1'b1));
            check_eq("t4 rdata", rd[0], pat32(32'hC0DE_0000 | 32'(i)));
            check_eq("t4 ready", 512'(rdy[0]), 512'(1'b1));
            if (i < 2) drive(0, 1'b1, 1'b0, i + 1, ZERO, 4'h0);
            else drive(0, 1'b0, 1'b0, 0, ZERO, 4'h0);
        end
        tick();
        check_eq("t4 pulse end", 512'(rv[0]), 512'(1'b0));
        check_eq("t4 hold", rd[0], pat32(32'hC0DE_0002));

        // Test 5: MCP=3, HOLD=0, then reset in the middle of a read.
        issue(2, 1'b1, 3, pat32(32'h5A5A_0003), 4'hF, "t5 wr");
        issue(2, 1'b0, 3, ZERO, 4'h0, "t5 rd");
        wait_resp(2, "t5", pat32(32'h5A5A_0003), 2);
        tick();
        check_eq("t5 hold0 clear", rd[2], ZERO);
        while (!rdy[2]) tick();
        drive(2, 1'b1, 1'b0, 3, ZERO, 4'h0);
        tick();
        drive(2, 1'b0, 1'b0, 0, ZERO, 4'h0);
        rst[2] = 1'b1;
        tick();
        rst[2] = 1'b0;
        check_eq("t5 no resp T+2", 512'(rv[2]), 512'(1'b0));
        check_eq("t5 ready T+2", 512'(rdy[2]), 512'(1'b0));
        tick();
        check_eq("t5 no resp T+3", 512'(rv[2]), 512'(1'b0));
        check_eq("t5 rdata T+3", rd[2], ZERO);
        check_eq("t5 ready T+3", 512'(rdy[2]), 512'(1'b1));
        tick();
        check_eq("t5 no resp T+4", 512'(rv[2]), 512'(1'b0));
        // A write presented during reset while ready is still high must be dropped.
        drive(2, 1'b1, 1'b1, 3, ZERO, 4'hF);
        rst[2] = 1'b1;
        tick();
        drive(2, 1'b0, 1'b0, 0, ZERO, 4'h0);
        rst[2] = 1'b0;
        tick();
        issue(2, 1'b0, 3, ZERO, 4'h0, "t5 rd after rst");
        wait_resp(2, "t5 rst write ignored", pat32(32'h5A5A_0003), 2);

        // Out-of-range addresses on a 12-deep, MCP=4 array.
        issue(3, 1'b1, 13, ONES, 4'hF, "oob wr");
        for (int c = 1; c <= 3; c++) begin
            check_eq("oob busy", 512'(rdy[3]), 512'(1'b0));
            tick();
        end
        check_eq("oob ready T+4", 512'(rdy[3]), 512'(1'b1));
        issue(3, 1'b1, 11, pat32(32'h0B0B_0011), 4'hF, "oob wr11");
        issue(3, 1'b0, 11, ZERO, 4'h0, "oob rd11");
        wait_resp(3, "oob in range", pat32(32'h0B0B_0011), 3);
        issue(3, 1'b0, 13, ZERO, 4'h0, "oob rd13");
        wait_resp(3, "oob read zero", ZERO, 3);

        // Test 6: random traffic against the scoreboard on every MCP.
        for (int k = 0; k < 4; k++) sb_run(k);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
